bcd_scan_counter: RTL and testbench

Four-digit BCD up/down counter with built-in display scanner, sitting directly upstream of the seven-segment decoder. It keeps a 0000–9999 count that advances at a prescaled rate and time-multiplexes one BCD digit at a time onto `bcd_out`, which drives the decoder's 4-bit BCD input. It also drives the matching active-low digit-enable lines. The decoder's 7-bit segment output plus `an_n` form the complete board display path.

---
 rtl/bcd_scan_counter.sv | 113 +++++++++++
 tb/tb_bcd_scan_counter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - four-digit BCD up/down counter with display scanner
module bcd_scan_counter #(
    parameter int CNT_DIV  = 50_000_000,
    parameter int SCAN_DIV = 50_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        up,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] digits,
    output logic [3:0]  bcd_out,
    output logic [3:0]  an_n,
    output logic        carry
);

    localparam int CW = $clog2(CNT_DIV);
    localparam int SW = $clog2(SCAN_DIV);

    logic [CW-1:0] pre;
    logic [SW-1:0] scnt;
    logic [1:0]    idx;
    logic [1:0]    idx_nxt;
    logic          pre_tc;
    logic          scan_tc;
    logic          step;
    logic          ripple;
    logic [15:0]   stepped;
    logic [15:0]   loaded;

    assign pre_tc  = (pre == CW'(CNT_DIV - 1));
    assign scan_tc = (scnt == SW'(SCAN_DIV - 1));
    assign step    = en && pre_tc && !clr && !load;
    assign idx_nxt = scan_tc ? idx + 2'd1 : idx;

    // Digit-wise ripple; ripple left set after the thousands digit means a wrap.
    always_comb begin
        stepped = digits;
        ripple  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (ripple) begin
                if (up) begin
                    if (digits[4*i +: 4] == 4'd9) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = digits[4*i +: 4] + 4'd1;
                        ripple            = 1'b0;
                    end
                end else begin
                    if (digits[4*i +: 4] == 4'd0) begin
                        stepped[4*i +: 4] = 4'd9;
                    end else begin
                        stepped[4*i +: 4] = digits[4*i +: 4] - 4'd1;
                        ripple            = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        loaded = '0;
        for (int i = 0; i < 4; i++) begin
            loaded[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd0 : load_val[4*i +: 4];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre    <= '0;
            digits <= '0;
            carry  <= 1'b0;
        end else begin
            carry <= 1'b0;
            if (clr) begin
                pre    <= '0;
                digits <= '0;
            end else if (load) begin
                pre    <= '0;
                digits <= loaded;
            end else if (en) begin
                if (pre_tc) begin
                    pre    <= '0;
                    digits <= stepped;
                    carry  <= ripple;
                end else begin
                    pre <= pre + 1'b1;
                end
            end
        end
    end

    // Select and value are loaded on the same edge from the same index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt    <= '0;
            idx     <= 2'd0;
            an_n    <= 4'b1110;
            bcd_out <= 4'h0;
        end else begin
            scnt    <= scan_tc ? '0 : scnt + 1'b1;
            idx     <= idx_nxt;
            an_n    <= ~(4'b0001 << idx_nxt);
            bcd_out <= digits[4*idx_nxt +: 4];
        end
    end

    logic unused_step;
    assign unused_step = step;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - randomized self-checking bench for bcd_scan_counter
module tb_bcd_scan_counter;

    localparam int CNT_DIV  = 4;
    localparam int SCAN_DIV = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, up, clr, load;
    logic [15:0] load_val;
    logic [15:0] digits;
    logic [3:0]  bcd_out;
    logic [3:0]  an_n;
    logic        carry;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: count kept as a plain integer 0..9999
    int m_cnt, m_pre, m_scnt, m_idx, m_bcd;
    bit m_carry;

    bcd_scan_counter #(.CNT_DIV(CNT_DIV), .SCAN_DIV(SCAN_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .digits(digits), .bcd_out(bcd_out), .an_n(an_n),
        .carry(carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pow10(input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p *= 10;
        return p;
    endfunction

    function automatic int dig_of(input int n, input int i);
        return (n / pow10(i)) % 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r = '0;
        for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'(dig_of(n, i));
        return r;
    endfunction

    function automatic int from_load(input logic [15:0] v);
        int val = 0;
        for (int i = 0; i < 4; i++) begin
            int nib = int'(v[4*i +: 4]);
            if (nib > 9) nib = 0;
            val += nib * pow10(i);
        end
        return val;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_pre = 0; m_scnt = 0; m_idx = 0; m_bcd = 0; m_carry = 0;
    endtask

    task automatic model_step();
        int old_cnt = m_cnt;
        if (m_scnt == SCAN_DIV - 1) begin
            m_scnt = 0;
            m_idx  = (m_idx + 1) % 4;
        end else begin
            m_scnt++;
        end
        m_bcd   = dig_of(old_cnt, m_idx);
        m_carry = 0;
        if (clr) begin
            m_cnt = 0; m_pre = 0;
        end else if (load) begin
            m_cnt = from_load(load_val); m_pre = 0;
        end else if (en) begin
            if (m_pre == CNT_DIV - 1) begin
                m_pre = 0;
                if (up) begin
                    m_carry = (m_cnt == 9999);
                    m_cnt   = (m_cnt + 1) % 10000;
                end else begin
                    m_carry = (m_cnt == 0);
                    m_cnt   = (m_cnt + 9999) % 10000;
                end
            end else begin
                m_pre++;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] a;
        a = ~(4'b0001 << m_idx);
        chk("digits", 32'(digits), 32'(to_bcd(m_cnt)));
        chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
        chk("an_n", 32'(an_n), 32'(a));
        chk("carry", 32'(carry), 32'(m_carry));
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic do_load(input logic [15:0] v);
        load = 1'b1; load_val = v;
        tick();
        load = 1'b0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; en = 1'b0; up = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        model_reset();
        repeat (2) tick();
        chk("rst_an_n", 32'(an_n), 32'h e);
        chk("rst_digits", 32'(digits), 32'h0);
        rst_n = 1'b1;

        en = 1'b1; up = 1'b1;
        repeat (40) tick();
        chk("up40", 32'(digits), 32'h0010);

        do_load(16'h9998);
        repeat (4) tick();
        chk("up_9999", 32'(digits), 32'h9999);
        repeat (3) tick();
        chk("up_wrap_early", 32'(carry), 32'h0);
        tick();
        chk("up_wrap", 32'(digits), 32'h0000);
        chk("up_carry", 32'(carry), 32'h1);
        tick();
        chk("up_carry_end", 32'(carry), 32'h0);

        up = 1'b0;
        do_load(16'h0100);
        repeat (4) tick();
        chk("borrow", 32'(digits), 32'h0099);
        do_load(16'h0000);
        repeat (4) tick();
        chk("dn_wrap", 32'(digits), 32'h9999);
        chk("dn_carry", 32'(carry), 32'h1);

        up = 1'b1;
        do_load(16'hA3F5);
        chk("bad_load", 32'(digits), 32'h0305);
        repeat (3) tick();
        clr = 1'b1; load = 1'b1; load_val = 16'h5555;
        tick();
        clr = 1'b0; load = 1'b0;
        chk("clr_prio", 32'(digits), 32'h0000);
        chk("clr_carry", 32'(carry), 32'h0);
        repeat (3) tick();
        chk("pre_restart_hold", 32'(digits), 32'h0000);
        tick();
        chk("pre_restart", 32'(digits), 32'h0001);

        do_load(16'h1234);
        en = 1'b0;
        repeat (16) tick();
        chk("scan_hold", 32'(digits), 32'h1234);

        en = 1'b1;
        do_load(16'h0057);
        repeat (2) tick();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        tick();
        #2 rst_n = 1'b1;
        n = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (digits != 16'h0) begin
                n = k;
                break;
            end
        end
        chk("first_step", 32'(n), 32'd4);

        for (int k = 0; k < 3000; k++) begin
            en   = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom);
            clr  = ($urandom_range(0, 63) == 0);
            load = ($urandom_range(0, 31) == 0);
            case ($urandom_range(0, 5))
                0: load_val = 16'h9999;
                1: load_val = 16'h0000;
                2: load_val = 16'h9998;
                3: load_val = 16'h0001;
                default: load_val = 16'($urandom);
            endcase
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
